// File: rtl/core_lsu.sv
// Load/store unit for the M stage: in-order store buffer that drains in the
// background, store-to-load forwarding, and a three-state memory port FSM.
module core_lsu #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_is_st,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    output logic              req_accept,
    output logic              ld_valid,
    output logic [DATA_W-1:0] ld_data,
    output logic              drained,
    output logic [CNT_W-1:0]  sb_count,
    input  logic [DATA_W-1:0] rd_data_M,
    input  logic              ready_M,
    output logic [DATA_W-1:0] wr_data_M,
    output logic [ADDR_W-1:0] addr_M,
    output logic [1:0]        enable_M
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ST_WAIT = 2'd1,
        LD_WAIT = 2'd2
    } port_state_t;

    port_state_t state, next_state;

    logic [ADDR_W-1:0] sb_addr [DEPTH];
    logic [DATA_W-1:0] sb_data [DEPTH];
    logic [PTR_W-1:0]  head, tail;
    logic [CNT_W-1:0]  count;

    logic              sb_full;
    logic              ld_req, st_req;
    logic              ld_hit, ld_miss;
    logic [DATA_W-1:0] hit_data;
    logic              port_rd, port_wr;
    logic              push, pop;
    logic              ld_hit_done, ld_mem_done;

    assign sb_full = (count == CNT_W'(DEPTH));
    assign ld_req  = req_valid & ~req_is_st;
    assign st_req  = req_valid &  req_is_st;

    // Scan oldest to youngest so the youngest matching store supplies the data
    always_comb begin : hit_scan
        logic [PTR_W-1:0] idx;
        idx      = '0;
        ld_hit   = 1'b0;
        hit_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = head + PTR_W'(k);
            if ((CNT_W'(k) < count) && (sb_addr[idx] == req_addr)) begin
                ld_hit   = 1'b1;
                hit_data = sb_data[idx];
            end
        end
    end

    assign ld_miss = ld_req & ~ld_hit;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (port_rd && !ready_M) begin
                    next_state = LD_WAIT;
                end else if (port_wr && !ready_M) begin
                    next_state = ST_WAIT;
                end
            end
            ST_WAIT: if (ready_M) next_state = IDLE;
            LD_WAIT: if (ready_M) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Load misses take the idle port ahead of buffered stores; a started access is held
    always_comb begin
        enable_M  = 2'b00;
        addr_M    = '0;
        wr_data_M = sb_data[head];
        case (state)
            IDLE: begin
                if (ld_miss) begin
                    enable_M = 2'b01;
                    addr_M   = req_addr;
                end else if (count != '0) begin
                    enable_M = 2'b10;
                    addr_M   = sb_addr[head];
                end
            end
            ST_WAIT: begin
                enable_M = 2'b10;
                addr_M   = sb_addr[head];
            end
            LD_WAIT: begin
                enable_M = 2'b01;
                addr_M   = req_addr;
            end
            default: enable_M = 2'b00;
        endcase
        if (reset) begin
            enable_M = 2'b00;
        end
    end

    assign port_rd     = (enable_M == 2'b01);
    assign port_wr     = (enable_M == 2'b10);
    assign ld_mem_done = port_rd & ready_M;
    assign pop         = port_wr & ready_M;
    assign ld_hit_done = ld_req & ld_hit & ~reset;
    assign push        = st_req & ~sb_full & ~reset;
    assign req_accept  = push | ld_hit_done | ld_mem_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + 1'b1;
            if (pop)  head <= head + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            sb_addr[tail] <= req_addr;
            sb_data[tail] <= req_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ld_valid <= 1'b0;
            ld_data  <= '0;
        end else begin
            ld_valid <= ld_hit_done | ld_mem_done;
            if (ld_hit_done) begin
                ld_data <= hit_data;
            end else if (ld_mem_done) begin
                ld_data <= rd_data_M;
            end
        end
    end

    assign sb_count = count;
    assign drained  = (count == '0) && (state == IDLE);

endmodule

// File: tb/tb_core_lsu.sv
// Self-checking bench for core_lsu: directed scenarios plus a randomized run
// against a queue-based store buffer / memory port model.
module tb_core_lsu;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 16;
    localparam int DEPTH  = 4;
    localparam int CNT_W  = 3;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } sb_entry_t;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid, req_is_st;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_data;
    logic              req_accept, ld_valid, drained;
    logic [DATA_W-1:0] ld_data;
    logic [CNT_W-1:0]  sb_count;
    logic [DATA_W-1:0] rd_data_M, wr_data_M;
    logic              ready_M;
    logic [ADDR_W-1:0] addr_M;
    logic [1:0]        enable_M;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    core_lsu #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_is_st(req_is_st), .req_addr(req_addr), .req_data(req_data),
        .req_accept(req_accept), .ld_valid(ld_valid), .ld_data(ld_data),
        .drained(drained), .sb_count(sb_count),
        .rd_data_M(rd_data_M), .ready_M(ready_M), .wr_data_M(wr_data_M),
        .addr_M(addr_M), .enable_M(enable_M)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_valid = 1'b0;
        req_is_st = 1'b0;
        req_addr  = '0;
        req_data  = '0;
    endtask

    task automatic drive_req(input logic is_st, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req_valid = 1'b1;
        req_is_st = is_st;
        req_addr  = a;
        req_data  = d;
        #1;
    endtask

    task automatic drain_all();
        idle_inputs();
        ready_M = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (drained === 1'b1) break;
            tick();
        end
        vectors++; if (drained !== 1'b1) begin miscompares++; $display("[TB] FAIL drain_timeout: drained=%b expected 1", drained); end
        ready_M = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; ready_M = 1'b0; rd_data_M = '0; idle_inputs();
        tick(); tick();
        vectors++; if (enable_M !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_enable: got %b expected 00", enable_M); end
        reset = 1'b0;
        #1;
        vectors++; if (sb_count !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_sb_count: got %0d expected 0", sb_count); end
        vectors++; if (enable_M !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_idle_enable: got %b expected 00", enable_M); end
        vectors++; if (drained !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_drained: got %b expected 1", drained); end
        vectors++; if (ld_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_ld_valid: got %b expected 0", ld_valid); end
        vectors++; if (ld_data !== 8'h00) begin miscompares++; $display("[TB] FAIL reset_ld_data: got %h expected 00", ld_data); end
    endtask

    task automatic test_store_full();
        ready_M = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive_req(1'b1, 16'h0100 + 16'(i), 8'h10 + 8'(i));
            vectors++; if (req_accept !== 1'b1) begin miscompares++; $display("[TB] FAIL full_store_accept%0d: got %b expected 1", i, req_accept); end
            tick();
        end
        drive_req(1'b1, 16'h0104, 8'h14);
        vectors++; if (req_accept !== 1'b0) begin miscompares++; $display("[TB] FAIL full_reject: got %b expected 0", req_accept); end
        vectors++; if (sb_count !== 3'd4) begin miscompares++; $display("[TB] FAIL full_count: got %0d expected 4", sb_count); end
        vectors++; if (enable_M !== 2'b10) begin miscompares++; $display("[TB] FAIL full_enable: got %b expected 10", enable_M); end
        vectors++; if (addr_M !== 16'h0100) begin miscompares++; $display("[TB] FAIL full_head_addr: got %h expected 0100", addr_M); end
        ready_M = 1'b1;
        #1;
        vectors++; if (req_accept !== 1'b0) begin miscompares++; $display("[TB] FAIL full_pop_no_free: got %b expected 0", req_accept); end
        vectors++; if (wr_data_M !== 8'h10) begin miscompares++; $display("[TB] FAIL full_head_data: got %h expected 10", wr_data_M); end
        tick();
        ready_M = 1'b0;
        #1;
        vectors++; if (sb_count !== 3'd3) begin miscompares++; $display("[TB] FAIL full_after_pop: got %0d expected 3", sb_count); end
        vectors++; if (req_accept !== 1'b1) begin miscompares++; $display("[TB] FAIL fifth_accept: got %b expected 1", req_accept); end
        tick();
        vectors++; if (sb_count !== 3'd4) begin miscompares++; $display("[TB] FAIL fifth_count: got %0d expected 4", sb_count); end
        drain_all();
    endtask

    task automatic test_load_forward();
        ready_M = 1'b0;
        drive_req(1'b1, 16'h0105, 8'h11);
        vectors++; if (req_accept !== 1'b1) begin miscompares++; $display("[TB] FAIL fwd_st1_accept: got %b expected 1", req_accept); end
        tick();
        drive_req(1'b1, 16'h0105, 8'h22);
        vectors++; if (req_accept !== 1'b1) begin miscompares++; $display("[TB] FAIL fwd_st2_accept: got %b expected 1", req_accept); end
        vectors++; if (enable_M !== 2'b10) begin miscompares++; $display("[TB] FAIL fwd_st2_enable: got %b expected 10", enable_M); end
        tick();
        drive_req(1'b0, 16'h0105, 8'h00);
        vectors++; if (req_accept !== 1'b1) begin miscompares++; $display("[TB] FAIL fwd_ld_accept: got %b expected 1", req_accept); end
        vectors++; if (enable_M !== 2'b10) begin miscompares++; $display("[TB] FAIL fwd_ld_port: got %b expected 10", enable_M); end
        tick();
        idle_inputs();
        vectors++; if (ld_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL fwd_ld_valid: got %b expected 1", ld_valid); end
        vectors++; if (ld_data !== 8'h22) begin miscompares++; $display("[TB] FAIL fwd_youngest: got %h expected 22", ld_data); end
        tick();
        vectors++; if (ld_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL fwd_pulse: got %b expected 0", ld_valid); end
        vectors++; if (ld_data !== 8'h22) begin miscompares++; $display("[TB] FAIL fwd_hold: got %h expected 22", ld_data); end
        drain_all();
    endtask

    task automatic test_load_behind_store();
        ready_M = 1'b0;
        drive_req(1'b1, 16'h0200, 8'h33);
        vectors++; if (req_accept !== 1'b1) begin miscompares++; $display("[TB] FAIL lbs_st_accept: got %b expected 1", req_accept); end
        tick();
        idle_inputs();
        tick();
        drive_req(1'b0, 16'h0300, 8'h00);
        vectors++; if (req_accept !== 1'b0) begin miscompares++; $display("[TB] FAIL lbs_ld_stall: got %b expected 0", req_accept); end
        vectors++; if (enable_M !== 2'b10) begin miscompares++; $display("[TB] FAIL lbs_enable: got %b expected 10", enable_M); end
        vectors++; if (addr_M !== 16'h0200) begin miscompares++; $display("[TB] FAIL lbs_addr: got %h expected 0200", addr_M); end
        vectors++; if (wr_data_M !== 8'h33) begin miscompares++; $display("[TB] FAIL lbs_wdata: got %h expected 33", wr_data_M); end
        tick();
        ready_M = 1'b1;
        #1;
        vectors++; if (req_accept !== 1'b0) begin miscompares++; $display("[TB] FAIL lbs_wait_retire: got %b expected 0", req_accept); end
        vectors++; if (enable_M !== 2'b10) begin miscompares++; $display("[TB] FAIL lbs_retire_enable: got %b expected 10", enable_M); end
        tick();
        rd_data_M = 8'h5A;
        #1;
        vectors++; if (enable_M !== 2'b01) begin miscompares++; $display("[TB] FAIL lbs_rd_enable: got %b expected 01", enable_M); end
        vectors++; if (addr_M !== 16'h0300) begin miscompares++; $display("[TB] FAIL lbs_rd_addr: got %h expected 0300", addr_M); end
        vectors++; if (req_accept !== 1'b1) begin miscompares++; $display("[TB] FAIL lbs_rd_accept: got %b expected 1", req_accept); end
        tick();
        idle_inputs();
        vectors++; if (ld_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL lbs_ld_valid: got %b expected 1", ld_valid); end
        vectors++; if (ld_data !== 8'h5A) begin miscompares++; $display("[TB] FAIL lbs_ld_data: got %h expected 5a", ld_data); end
        vectors++; if (sb_count !== 3'd0) begin miscompares++; $display("[TB] FAIL lbs_count: got %0d expected 0", sb_count); end
        drain_all();
    endtask

    task automatic test_wrap_order();
        sb_entry_t q[$];
        int issued = 0;
        logic [DATA_W-1:0] cur_d = 8'($urandom);
        logic [1:0] exp_en;
        logic exp_acc;
        for (int cyc = 0; cyc < 200 && (issued < 10 || q.size() > 0); cyc++) begin
            ready_M = cyc[0];
            if (issued < 10) drive_req(1'b1, 16'h0400 + 16'(issued), cur_d);
            else begin idle_inputs(); #1; end
            exp_en  = (q.size() > 0) ? 2'b10 : 2'b00;
            exp_acc = (issued < 10) && (q.size() < DEPTH);
            vectors++; if (enable_M !== exp_en) begin miscompares++; $display("[TB] FAIL wrap_enable: got %b expected %b", enable_M, exp_en); end
            vectors++; if (req_accept !== exp_acc) begin miscompares++; $display("[TB] FAIL wrap_accept: got %b expected %b", req_accept, exp_acc); end
            if (exp_en == 2'b10) begin
                vectors++; if (addr_M !== q[0].addr) begin miscompares++; $display("[TB] FAIL wrap_order_addr: got %h expected %h", addr_M, q[0].addr); end
                vectors++; if (wr_data_M !== q[0].data) begin miscompares++; $display("[TB] FAIL wrap_order_data: got %h expected %h", wr_data_M, q[0].data); end
                if (ready_M) void'(q.pop_front());
            end
            if (exp_acc) begin
                q.push_back('{addr: 16'h0400 + 16'(issued), data: cur_d});
                issued++;
                cur_d = 8'($urandom);
            end
            tick();
        end
        idle_inputs();
        ready_M = 1'b0;
        #1;
        vectors++; if (issued != 10 || q.size() != 0) begin miscompares++; $display("[TB] FAIL wrap_timeout: issued %0d left %0d expected 10 and 0", issued, q.size()); end
        vectors++; if (sb_count !== 3'd0) begin miscompares++; $display("[TB] FAIL wrap_final_count: got %0d expected 0", sb_count); end
        vectors++; if (drained !== 1'b1) begin miscompares++; $display("[TB] FAIL wrap_drained: got %b expected 1", drained); end
    endtask

    task automatic test_reset_mid_wait();
        ready_M = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_req(1'b1, 16'h0700 + 16'(i), 8'hA0 + 8'(i));
            tick();
        end
        idle_inputs();
        tick();
        vectors++; if (sb_count !== 3'd3) begin miscompares++; $display("[TB] FAIL rmw_count_before: got %0d expected 3", sb_count); end
        vectors++; if (drained !== 1'b0) begin miscompares++; $display("[TB] FAIL rmw_not_drained: got %b expected 0", drained); end
        reset = 1'b1;
        #1;
        vectors++; if (enable_M !== 2'b00) begin miscompares++; $display("[TB] FAIL rmw_enable_forced: got %b expected 00", enable_M); end
        tick();
        vectors++; if (sb_count !== 3'd0) begin miscompares++; $display("[TB] FAIL rmw_count_after: got %0d expected 0", sb_count); end
        reset = 1'b0;
        #1;
        vectors++; if (drained !== 1'b1) begin miscompares++; $display("[TB] FAIL rmw_drained: got %b expected 1", drained); end
        vectors++; if (enable_M !== 2'b00) begin miscompares++; $display("[TB] FAIL rmw_enable_idle: got %b expected 00", enable_M); end
        ready_M = 1'b1; rd_data_M = 8'h77;
        drive_req(1'b0, 16'h0700, 8'h00);
        vectors++; if (enable_M !== 2'b01) begin miscompares++; $display("[TB] FAIL rmw_ld_enable: got %b expected 01", enable_M); end
        vectors++; if (addr_M !== 16'h0700) begin miscompares++; $display("[TB] FAIL rmw_ld_addr: got %h expected 0700", addr_M); end
        vectors++; if (req_accept !== 1'b1) begin miscompares++; $display("[TB] FAIL rmw_ld_accept: got %b expected 1", req_accept); end
        tick();
        idle_inputs();
        vectors++; if (ld_data !== 8'h77) begin miscompares++; $display("[TB] FAIL rmw_ld_data: got %h expected 77", ld_data); end
        ready_M = 1'b0;
    endtask

    task automatic test_random();
        sb_entry_t q[$];
        int pend;
        logic have, cur_st, hit, exp_ldv, exp_acc;
        logic [ADDR_W-1:0] cur_a, exp_addr;
        logic [DATA_W-1:0] cur_d, hit_d, exp_ldd;
        logic [1:0] exp_en;
        reset = 1'b1; ready_M = 1'b0; idle_inputs();
        tick();
        reset = 1'b0;
        pend = 0; have = 1'b0; cur_st = 1'b0; cur_a = '0; cur_d = '0;
        exp_ldv = 1'b0; exp_ldd = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            vectors++; if (ld_valid !== exp_ldv) begin miscompares++; $display("[TB] FAIL rnd_ld_valid cyc%0d: got %b expected %b", cyc, ld_valid, exp_ldv); end
            vectors++; if (ld_data !== exp_ldd) begin miscompares++; $display("[TB] FAIL rnd_ld_data cyc%0d: got %h expected %h", cyc, ld_data, exp_ldd); end
            vectors++; if (sb_count !== CNT_W'(q.size())) begin miscompares++; $display("[TB] FAIL rnd_count cyc%0d: got %0d expected %0d", cyc, sb_count, q.size()); end
            vectors++; if (drained !== (q.size() == 0 && pend == 0)) begin miscompares++; $display("[TB] FAIL rnd_drained cyc%0d: got %b expected %b", cyc, drained, (q.size() == 0 && pend == 0)); end
            if (!have && cyc < 380 && $urandom_range(0, 3) != 0) begin
                have   = 1'b1;
                cur_st = 1'($urandom_range(0, 1));
                cur_a  = 16'h0600 + 16'($urandom_range(0, 5));
                cur_d  = 8'($urandom);
            end
            req_valid = have; req_is_st = cur_st; req_addr = cur_a; req_data = cur_d;
            ready_M   = 1'($urandom_range(0, 1));
            rd_data_M = 8'($urandom);
            #1;
            hit = 1'b0; hit_d = '0;
            if (have && !cur_st) foreach (q[i]) if (q[i].addr == cur_a) begin hit = 1'b1; hit_d = q[i].data; end
            exp_addr = '0;
            if (pend == 2)                      begin exp_en = 2'b01; exp_addr = cur_a; end
            else if (pend == 1)                 begin exp_en = 2'b10; exp_addr = q[0].addr; end
            else if (have && !cur_st && !hit)   begin exp_en = 2'b01; exp_addr = cur_a; end
            else if (q.size() > 0)              begin exp_en = 2'b10; exp_addr = q[0].addr; end
            else                                exp_en = 2'b00;
            exp_acc = have && (cur_st ? (q.size() < DEPTH) : (hit || (exp_en == 2'b01 && ready_M)));
            vectors++; if (enable_M !== exp_en) begin miscompares++; $display("[TB] FAIL rnd_enable cyc%0d: got %b expected %b", cyc, enable_M, exp_en); end
            vectors++; if (req_accept !== exp_acc) begin miscompares++; $display("[TB] FAIL rnd_accept cyc%0d: got %b expected %b", cyc, req_accept, exp_acc); end
            if (exp_en != 2'b00) begin
                vectors++; if (addr_M !== exp_addr) begin miscompares++; $display("[TB] FAIL rnd_addr cyc%0d: got %h expected %h", cyc, addr_M, exp_addr); end
            end
            if (exp_en == 2'b10) begin
                vectors++; if (wr_data_M !== q[0].data) begin miscompares++; $display("[TB] FAIL rnd_wdata cyc%0d: got %h expected %h", cyc, wr_data_M, q[0].data); end
            end
            exp_ldv = have && !cur_st && exp_acc;
            if (exp_ldv) exp_ldd = hit ? hit_d : rd_data_M;
            if (exp_en == 2'b10 && ready_M) void'(q.pop_front());
            if (have && cur_st && exp_acc) q.push_back('{addr: cur_a, data: cur_d});
            pend = (exp_en != 2'b00 && !ready_M) ? ((exp_en == 2'b01) ? 2 : 1) : 0;
            if (exp_acc) have = 1'b0;
            tick();
        end
        drain_all();
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_store_full();
        test_load_forward();
        test_load_behind_store();
        test_wrap_order();
        test_reset_mid_wait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/core_lsu.md
# core_lsu

Parametrised load/store unit for the DSP core's M stage, replacing the blocking single-access memory stage. Stores retire into a DEPTH-entry in-order store buffer and drain to the memory port in the background, so the pipeline does not stall on them. Loads are forwarded from the buffer on an address hit, otherwise issued to memory with priority over buffered stores. It sits between the core's XM/MW pipeline registers and the shared memory port (`rd_data_M`/`ready_M`/`wr_data_M`/`addr_M`/`enable_M`).

## Interface
- DATA_W, 8, data width (core register width)
- ADDR_W, 16, address width ({core id, offset})
- DEPTH, 4, store buffer entries; power of 2, ≥2
- CNT_W, $clog2(DEPTH)+1, width of sb_count
- clk  in  1  clock; single clock domain
- reset  in  1  synchronous, active-high
- req_valid  in  1  M stage holds an LD or ST
- req_is_st  in  1  1 = ST, 0 = LD; valid with req_valid
- req_addr  in  ADDR_W  access address
- req_data  in  DATA_W  store data
- req_accept  out  1  request consumed this cycle (combinational); core stalls while req_valid & ~req_accept
- ld_valid  out  1  registered one-cycle pulse, load data ready
- ld_data  out  DATA_W  registered load result; holds until next load
- drained  out  1  buffer empty and port idle (core's READY waits on it)
- sb_count  out  CNT_W  buffered stores
- rd_data_M  in  DATA_W  memory read data
- ready_M  in  1  memory completes the driven access this cycle
- wr_data_M  out  DATA_W  memory write data
- addr_M  out  ADDR_W  memory address
- enable_M  out  2  00 idle, 01 read, 10 write

## Operation
- Buffer: circular FIFO; head/tail pointers mod DEPTH; each entry {addr, data}.
- Store: req_accept=1 iff sb_count<DEPTH; written at tail. Count is not freed by a same-cycle pop (full → reject even if head retires).
- Load hit: any valid entry addr == req_addr → req_accept=1 same cycle; youngest matching entry's data is captured into ld_data. No memory access.
- Load miss: goes to memory via the port FSM.
- Port FSM states: IDLE, ST_WAIT, LD_WAIT.
  - IDLE: a load miss pending → drive 01 with req_addr. Else if sb_count>0 → drive 10 with the head entry. Else drive 00. If ready_M=1, the access completes (load: accept + capture rd_data_M; store: pop head) and the FSM stays in IDLE. If ready_M=0, go to LD_WAIT or ST_WAIT.
  - ST_WAIT: keep driving the head store, addr/data stable. Load misses wait. On ready_M, pop and go to IDLE.
  - LD_WAIT: keep driving the read, req_addr stable (the core holds the M stage). On ready_M, accept, capture, and go to IDLE.
- Load hits are served in any state, including ST_WAIT; they do not disturb the port.
- Push and pop in the same cycle: sb_count unchanged.
- drained = (sb_count==0) & (state==IDLE).
- Reset: pointers 0, sb_count 0, state IDLE, ld_valid 0, ld_data 0. enable_M is forced to 00 while reset is high. A store or read in flight is abandoned and buffered stores are discarded. After reset, drained=1.

## Timing
- Store accept: 0 cycles (combinational) when not full.
- Load hit: req_accept in cycle N; ld_valid/ld_data in cycle N+1.
- Load miss: req_accept in the cycle with enable_M=01 & ready_M=1; ld_valid next cycle. Best case 0-cycle accept with an idle port.
- Store retire: one entry per ready_M cycle at most. Back-to-back pops with ready_M held high.
- Memory outputs are combinational from state/buffer/req. They are stable across wait cycles.

## Test plan
- Reset → sb_count=0, enable_M=00, drained=1, ld_valid=0, ld_data=0.
- DEPTH=4, ready_M=0: 5 stores to 0x0100..0x0104. First 4 are accepted; 5th has req_accept=0. enable_M=10 with addr_M=0x0100. Pulse ready_M → 0x0100 pops and sb_count=3; 5th is accepted the next cycle.
- ST 0x0105←0x11, ST 0x0105←0x22, ready_M=0; then LD 0x0105 → accepted same cycle, next cycle ld_valid=1 and ld_data=0x22. enable_M never 01.
- ST 0x0200←0x33 stuck in ST_WAIT; LD 0x0300 (miss) stalls. ready_M=1 retires the store; then enable_M=01 with addr_M=0x0300, rd_data_M=0x5A → ld_data=0x5A.
- 10 stores with ready_M toggling every cycle → addr_M write order equals issue order across pointer wrap; final sb_count=0, drained=1.
- Reset asserted during ST_WAIT with sb_count=3 → next cycle sb_count=0, enable_M=00, state IDLE. A subsequent LD miss issues immediately.
